// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm
//   Debounces one raw push-button. The button is sampled only on tick cycles
//   (1 ms strobes). A press or a release is accepted only after STABLE_TICKS
//   consecutive agreeing samples. While the button is held, the block emits
//   auto-repeat strobes: the first after HOLD_TICKS, then one every REPEAT_TICKS.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   tick           1-cycle sample strobe from the upstream pulse generator
//   btn_in         raw asynchronous button, active-high
//   btn_level      debounced button level (registered)
//   press_pulse    1-clk strobe on an accepted press
//   repeat_pulse   1-clk strobe per auto-repeat while held
//   release_pulse  1-clk strobe on an accepted release
module button_debounce_fsm #(
  parameter int STABLE_TICKS = 20,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] STB = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] HLD = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] RPT = CNT_W'(REPEAT_TICKS);

  typedef enum logic [2:0] {
    IDLE,
    ARM_PRESS,
    PRESSED,
    REPEAT,
    ARM_RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             meta, sync;

  // Two-flop synchronizer; only sync is ever looked at by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // Strobes drop back after one clk unless re-asserted below.
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (sync) begin
              // With STABLE_TICKS==1 the first agreeing sample already qualifies.
              if (ONE == STB) begin
                state       <= PRESSED;
                cnt         <= '0;
                press_pulse <= 1'b1;
                btn_level   <= 1'b1;
              end else begin
                state <= ARM_PRESS;
                cnt   <= ONE;
              end
            end
          end
          ARM_PRESS: begin
            if (!sync) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt_inc == STB) begin
              state       <= PRESSED;
              cnt         <= '0;
              press_pulse <= 1'b1;
              btn_level   <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          PRESSED, REPEAT: begin
            if (!sync) begin
              if (ONE == STB) begin
                state         <= IDLE;
                cnt           <= '0;
                release_pulse <= 1'b1;
                btn_level     <= 1'b0;
              end else begin
                state <= ARM_RELEASE;
                cnt   <= ONE;
              end
            end else if (cnt_inc == ((state == PRESSED) ? HLD : RPT)) begin
              state        <= REPEAT;
              cnt          <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ARM_RELEASE: begin
            if (sync) begin
              // Bounce back to held: hold delay restarts, no new press strobe.
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt_inc == STB) begin
              state         <= IDLE;
              cnt           <= '0;
              release_pulse <= 1'b1;
              btn_level     <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Testbench for button_debounce_fsm with STABLE_TICKS=4, HOLD_TICKS=10,
// REPEAT_TICKS=3 and a tick every 5 clk. Expected strobes (kind + tick number)
// are queued by the stimulus; a monitor pops and compares on every strobe.
module tb_button_debounce_fsm;

  localparam int K_PRESS   = 1;
  localparam int K_REPEAT  = 2;
  localparam int K_RELEASE = 3;

  logic clk, rst, tick, btn_in;
  logic btn_level, press_pulse, repeat_pulse, release_pulse;

  typedef struct {
    int kind;
    int tk;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  tick_num = 0;

  button_debounce_fsm #(
    .STABLE_TICKS(4),
    .HOLD_TICKS  (10),
    .REPEAT_TICKS(3),
    .CNT_W       (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (press_pulse || repeat_pulse || release_pulse) begin
      int  n, kind;
      ev_t e;
      n    = int'(press_pulse) + int'(repeat_pulse) + int'(release_pulse);
      kind = press_pulse ? K_PRESS : (repeat_pulse ? K_REPEAT : K_RELEASE);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind=%0d at tick %0d, expected none", kind, tick_num);
      end else begin
        e = q.pop_front();
        if (e.kind != kind || e.tk != tick_num || n != 1) begin
          errors++;
          $display("FAIL pulse: got kind=%0d tick=%0d strobes=%0d, expected kind=%0d tick=%0d strobes=1",
                   kind, tick_num, n, e.kind, e.tk);
        end
        checks++;
        if (btn_level != (kind != K_RELEASE)) begin
          errors++;
          $display("FAIL level_at_pulse: got %0b, expected %0b", btn_level, kind != K_RELEASE);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int tk);
    ev_t e;
    e.kind = kind;
    e.tk   = tk;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    btn_in = 1'b0;
    tick   = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick_num = 0;
  endtask

  // Bit k of pat is the button value sampled on tick k+1.
  task automatic run(input logic [31:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      btn_in = pat[k];
      repeat (4) @(posedge clk);
      #1 tick = 1'b1;
      tick_num++;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  task automatic check_done(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses missing, first kind=%0d tick=%0d",
               name, q.size(), q[0].kind, q[0].tk);
      q.delete();
    end
  endtask

  initial begin
    rst    = 1'b1;
    tick   = 1'b0;
    btn_in = 1'b0;
    #23;
    chk("reset_level",   btn_level,     1'b0);
    chk("reset_press",   press_pulse,   1'b0);
    chk("reset_repeat",  repeat_pulse,  1'b0);
    chk("reset_release", release_pulse, 1'b0);

    // 1: held for 6 ticks, then released.
    do_reset();
    expect_ev(K_PRESS, 4);
    expect_ev(K_RELEASE, 10);
    run(32'h0000_003F, 12);
    check_done("t1_done");
    chk("t1_level", btn_level, 1'b0);

    // 2: bounce on tick 4 restarts qualification.
    do_reset();
    expect_ev(K_PRESS, 8);
    run(32'h0000_00F7, 8);
    check_done("t2_done");
    chk("t2_level", btn_level, 1'b1);

    // 3: long hold with auto-repeat.
    do_reset();
    expect_ev(K_PRESS, 4);
    expect_ev(K_REPEAT, 14);
    expect_ev(K_REPEAT, 17);
    expect_ev(K_REPEAT, 20);
    run(32'h000F_FFFF, 20);
    check_done("t3_done");

    // 4: one-tick dropout on tick 8 restarts the hold delay.
    do_reset();
    expect_ev(K_PRESS, 4);
    expect_ev(K_REPEAT, 19);
    run(32'h000F_FF7F, 20);
    check_done("t4_done");
    chk("t4_level", btn_level, 1'b1);

    // 5: reset while pressed, button still held afterwards.
    do_reset();
    expect_ev(K_PRESS, 4);
    run(32'h0000_003F, 6);
    chk("t5_level_before_rst", btn_level, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_level_in_rst",   btn_level,     1'b0);
    chk("t5_release_in_rst", release_pulse, 1'b0);
    chk("t5_press_in_rst",   press_pulse,   1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick_num = 0;
    check_done("t5_no_pulse_in_rst");
    expect_ev(K_PRESS, 4);
    run(32'h0000_000F, 4);
    check_done("t5_done");

    // 6: button chatter with no ticks must not move the FSM.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 btn_in = ~btn_in;
    end
    btn_in = 1'b0;
    check_done("t6_no_pulse");
    chk("t6_level", btn_level, 1'b0);
    expect_ev(K_PRESS, 4);
    run(32'h0000_000F, 4);
    check_done("t6_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
